// File: rtl/cell_bist_ctrl_if.sv
// Purpose: bundles the test-control, cell-stimulus and result signals of the cell BIST controller.
// Latency: none; this is wiring only.
// Backpressure: none; start/abort are level-sampled by the controller, with no handshake.
//
// Port summary (controller / slave view):
//   start, abort     in   run control from the chip test logic
//   dut_y            in   output of the cell under test
//   dut_in           out  stimulus vector to the cell (bit N_IN-1 = A ... bit 0 = C)
//   busy, done       out  run status; done is a one-cycle end-of-run pulse
//   pass, err_count  out  result of the last run
//   first_fail,
//   fail_valid       out  lowest failing vector and its qualifier
interface cell_bist_ctrl_if #(
    parameter int N_IN = 3
);
    logic            start;
    logic            abort;
    logic            dut_y;
    logic [N_IN-1:0] dut_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_fail;
    logic            fail_valid;

    modport slave (
        input  start,
        input  abort,
        input  dut_y,
        output dut_in,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_fail,
        output fail_valid
    );

    modport master (
        output start,
        output abort,
        output dut_y,
        input  dut_in,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_fail,
        input  fail_valid
    );
endinterface

// File: rtl/cell_bist_ctrl.sv
// Purpose: exhaustive BIST of one combinational cell against a golden truth table.
// Latency: 2**N_IN*(SETTLE_CYCLES+1) cycles from accepted start to the done pulse.
// Backpressure: none; start is ignored unless idle, abort ends a run early.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, clears all state with no done pulse
//   bus    cell_bist_ctrl_if.slave: start/abort/dut_y in, stimulus and results out
module cell_bist_ctrl #(
    parameter int                    N_IN          = 3,
    parameter logic [(1<<N_IN)-1:0]  GOLDEN        = 8'h57,
    parameter int                    SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    cell_bist_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0]      CNT_RELOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST   = '1;
    localparam logic [N_IN:0]   ERR_MAX    = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN:0]   ERR_ONE    = {{N_IN{1'b0}}, 1'b1};
    localparam logic [N_IN-1:0] VEC_ONE    = {{(N_IN-1){1'b0}}, 1'b1};

    state_t          state_q, state_n;
    logic [3:0]      cnt_q, cnt_n;
    logic [N_IN-1:0] vec_q, vec_n;
    logic [N_IN:0]   err_q, err_n;
    logic [N_IN-1:0] ff_q, ff_n;
    logic            fv_q, fv_n;
    logic            pass_q, pass_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;
    logic            mismatch;

    assign mismatch = (bus.dut_y != GOLDEN[vec_q]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            fv_q    <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            vec_q   <= vec_n;
            err_q   <= err_n;
            ff_q    <= ff_n;
            fv_q    <= fv_n;
            pass_q  <= pass_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        vec_n   = vec_q;
        err_n   = err_q;
        ff_n    = ff_q;
        fv_n    = fv_q;
        pass_n  = pass_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n = APPLY;
                    cnt_n   = CNT_RELOAD;
                    vec_n   = '0;
                    err_n   = '0;
                    ff_n    = '0;
                    fv_n    = 1'b0;
                    pass_n  = 1'b0;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    state_n = FINISH;
                    vec_n   = '0;
                    pass_n  = 1'b0;
                end else if (cnt_q == '0) begin
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                // The comparison is recorded even when abort arrives in this cycle.
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_n = err_q + ERR_ONE;
                    end
                    if (!fv_q) begin
                        ff_n = vec_q;
                        fv_n = 1'b1;
                    end
                end
                if (bus.abort || (vec_q == VEC_LAST)) begin
                    state_n = FINISH;
                    vec_n   = '0;
                    // err_n already includes this cycle's mismatch.
                    pass_n  = !bus.abort && (err_n == '0);
                end else begin
                    state_n = APPLY;
                    vec_n   = vec_q + VEC_ONE;
                    cnt_n   = CNT_RELOAD;
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Status flags are registered copies of the next state.
        busy_n = (state_n == APPLY) || (state_n == SAMPLE);
        done_n = (state_n == FINISH);
    end

    assign bus.dut_in     = vec_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
    assign bus.fail_valid = fv_q;

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Purpose: directed, self-checking bench for cell_bist_ctrl with a scoreboard of run results.
// Latency: expects done 2**N_IN*(SETTLE_CYCLES+1) edges after the start edge.
// Backpressure: not applicable; the bench drives start/abort directly.
module tb_cell_bist_ctrl;

    localparam int N_IN   = 3;
    localparam int SETTLE = 2;
    localparam int NVEC   = 1 << N_IN;
    localparam int PERIOD = SETTLE + 1;

    localparam int M_IDEAL = 0;
    localparam int M_STUCK = 1;
    localparam int M_INV   = 2;

    typedef struct {
        int err;
        int ff;
        int fv;
        int pass;
        int done_k;
    } exp_t;

    logic clk;
    logic reset;
    int   mode;
    int   checks;
    int   errors;
    exp_t sb[$];

    cell_bist_ctrl_if #(.N_IN(N_IN)) bus ();

    cell_bist_ctrl #(
        .N_IN          (N_IN),
        .GOLDEN        (8'h57),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic golden_y(input int v);
        logic [2:0] vb;
        vb = v[2:0];
        return ~((vb[2] | vb[1]) & vb[0]);
    endfunction

    function automatic logic cell_y(input int m, input int v);
        logic [2:0] vb;
        vb = v[2:0];
        case (m)
            M_STUCK: return 1'b1;
            M_INV:   return (vb[2] | vb[1]) & vb[0];
            default: return ~((vb[2] | vb[1]) & vb[0]);
        endcase
    endfunction

    // Behavioural cell under test.
    always_comb bus.dut_y = cell_y(mode, int'(bus.dut_in));

    function automatic exp_t model_run(input int m, input int n_vec, input bit aborted, input int done_k);
        exp_t e;
        e.err = 0;
        e.ff = 0;
        e.fv = 0;
        for (int v = 0; v < n_vec; v++) begin
            if (cell_y(m, v) != golden_y(v)) begin
                if (e.err < NVEC) e.err = e.err + 1;
                if (e.fv == 0) begin
                    e.ff = v;
                    e.fv = 1;
                end
            end
        end
        e.pass = (!aborted && e.err == 0) ? 1 : 0;
        e.done_k = done_k;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One run: start is sampled at edge 0; extra start pulses and abort are
    // sampled at the given edge index (-1 = never).
    task automatic run_check(input int m, input int s2_k, input int s3_k, input int abort_k);
        exp_t e;
        bit   seen_done;
        bit   aborted;
        int   n_vec;
        int   done_k;
        aborted = (abort_k >= 0);
        n_vec   = aborted ? (abort_k - 1) / PERIOD : NVEC;
        done_k  = aborted ? abort_k : NVEC * PERIOD;
        mode    = m;
        sb.push_back(model_run(m, n_vec, aborted, done_k));
        seen_done = 1'b0;
        bus.start = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            tick();
            bus.start = ((k + 1) == s2_k) || ((k + 1) == s3_k);
            bus.abort = ((k + 1) == abort_k);
            if (!seen_done) begin
                if (k == 0) begin
                    chk("clear_err", bus.err_count, 0);
                    chk("clear_fv", bus.fail_valid, 0);
                end
                if (bus.done) begin
                    seen_done = 1'b1;
                    e = sb.pop_front();
                    chk("done_edge", k, e.done_k);
                    chk("err_count", bus.err_count, e.err);
                    chk("first_fail", bus.first_fail, e.ff);
                    chk("fail_valid", bus.fail_valid, e.fv);
                    chk("pass", bus.pass, e.pass);
                    chk("fin_dut_in", bus.dut_in, 0);
                    chk("fin_busy", bus.busy, 0);
                end else begin
                    chk("run_busy", bus.busy, 1);
                    chk("run_dut_in", bus.dut_in, k / PERIOD);
                end
            end else begin
                chk("idle_done", bus.done, 0);
                chk("idle_busy", bus.busy, 0);
                break;
            end
        end
        if (!seen_done) chk("done_timeout", 0, 1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mode      = M_IDEAL;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) tick();
        chk("rst_dut_in", bus.dut_in, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_err", bus.err_count, 0);
        chk("rst_ff", bus.first_fail, 0);
        chk("rst_fv", bus.fail_valid, 0);
        reset = 1'b0;
        tick();

        // Ideal cell: clean pass.
        run_check(M_IDEAL, -1, -1, -1);
        // Stuck-at-1 with ignored start pulses at edges 5 and 24.
        run_check(M_STUCK, 5, 24, -1);
        // Back-to-back ideal run clears results; start in FINISH ignored.
        run_check(M_IDEAL, -1, NVEC * PERIOD + 1, -1);
        // Inverted cell: every vector fails.
        run_check(M_INV, -1, -1, -1);
        // Abort during APPLY of vector 4 with stuck-at-1 cell.
        run_check(M_STUCK, -1, -1, 4 * PERIOD + 1);

        // Abort while idle has no effect and results hold.
        bus.abort = 1'b1;
        repeat (2) tick();
        bus.abort = 1'b0;
        chk("idle_abort_busy", bus.busy, 0);
        chk("idle_abort_done", bus.done, 0);
        chk("hold_err", bus.err_count, 1);
        chk("hold_ff", bus.first_fail, 3);
        chk("hold_fv", bus.fail_valid, 1);
        chk("hold_pass", bus.pass, 0);

        // Reset mid-run while dut_in = 5.
        mode = M_STUCK;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 5 * PERIOD; k++) tick();
        chk("pre_rst_dut_in", bus.dut_in, 5);
        chk("pre_rst_err", bus.err_count, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_dut_in", bus.dut_in, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_err", bus.err_count, 0);
        chk("mid_rst_ff", bus.first_fail, 0);
        chk("mid_rst_fv", bus.fail_valid, 0);
        chk("mid_rst_pass", bus.pass, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_done", bus.done, 0);
            chk("post_rst_busy", bus.busy, 0);
        end

        // Clean full run after reset.
        run_check(M_IDEAL, -1, -1, -1);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
